ysyx_22050039_fetch_unit: RTL

Parametrised, decoupled instruction fetch unit. It is the successor to the single-cycle PC-register IFU. It owns the fetch PC and issues pipelined requests to instruction memory over a valid/ready channel, with up to MAX_OUTST requests in flight. Returned instructions are buffered in a FIFO_DEPTH queue feeding decode through valid/ready. A redirect from EXU flushes the queue, discards stale in-flight responses and restarts fetch; a misaligned redirect raises a fetch fault.

---
 rtl/ysyx_22050039_fetch_unit.sv | 209 ++++++++++++++++++++
 1 files changed

// File: rtl/ysyx_22050039_fetch_unit.sv
// rtl/ysyx_22050039_fetch_unit.sv - decoupled instruction fetch unit with credit-limited
// pipelined memory requests, an in-order tag queue and a registered instruction queue.
module ysyx_22050039_fetch_unit #(
    parameter int              XLEN       = 64,
    parameter int              ILEN       = 32,
    parameter logic [XLEN-1:0] RESET_PC   = 64'h80000000,
    parameter int              FIFO_DEPTH = 4,
    parameter int              MAX_OUTST  = 2
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    output logic            imem_req_valid,
    input  logic            imem_req_ready,
    output logic [XLEN-1:0] imem_req_addr,
    input  logic            imem_resp_valid,
    input  logic [ILEN-1:0] imem_resp_data,
    input  logic            imem_resp_err,
    output logic            inst_valid,
    input  logic            inst_ready,
    output logic [ILEN-1:0] inst,
    output logic [XLEN-1:0] inst_pc,
    output logic            inst_err,
    output logic [XLEN-1:0] fetch_pc
);

    localparam int QAW = $clog2(FIFO_DEPTH);
    localparam int QCW = $clog2(FIFO_DEPTH + 1);
    localparam int TAW = (MAX_OUTST > 1) ? $clog2(MAX_OUTST) : 1;
    localparam int OCW = $clog2(MAX_OUTST + 1);

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_FAULT = 2'd1,
        ST_HALT  = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;

    logic [ILEN-1:0] q_inst_q [FIFO_DEPTH];
    logic [ILEN-1:0] q_inst_d [FIFO_DEPTH];
    logic [XLEN-1:0] q_pc_q   [FIFO_DEPTH];
    logic [XLEN-1:0] q_pc_d   [FIFO_DEPTH];
    logic            q_err_q  [FIFO_DEPTH];
    logic            q_err_d  [FIFO_DEPTH];
    logic [QAW-1:0]  q_head_q, q_head_d;
    logic [QAW-1:0]  q_tail_q, q_tail_d;
    logic [QCW-1:0]  q_count_q, q_count_d;

    logic [XLEN-1:0] tag_q [MAX_OUTST];
    logic [XLEN-1:0] tag_d [MAX_OUTST];
    logic [TAW-1:0]  tag_head_q, tag_head_d;
    logic [TAW-1:0]  tag_tail_q, tag_tail_d;

    logic [OCW-1:0]  outst_q, outst_d;
    logic [OCW-1:0]  drop_q, drop_d;

    logic            outst_room;
    logic            queue_room;
    logic            req_fire;
    logic            resp_keep;
    logic            fault_enq;
    logic            enq;
    logic            deq;
    logic [ILEN-1:0] enq_inst;
    logic [XLEN-1:0] enq_pc;
    logic            enq_err;

    // A request is only issued if its eventual response is guaranteed a queue slot.
    assign outst_room = outst_q < OCW'(MAX_OUTST);
    assign queue_room = ({1'b0, q_count_q} + (QCW+1)'(outst_q)) < (QCW+1)'(FIFO_DEPTH);

    assign imem_req_valid = !rst && (state_q == ST_RUN) && !redirect_valid
                            && outst_room && queue_room;
    assign imem_req_addr  = fetch_pc_q;
    assign fetch_pc       = fetch_pc_q;
    assign req_fire       = imem_req_valid && imem_req_ready;

    assign inst_valid = (q_count_q != '0);
    assign inst       = inst_valid ? q_inst_q[q_head_q] : '0;
    assign inst_pc    = inst_valid ? q_pc_q[q_head_q]   : '0;
    assign inst_err   = inst_valid ? q_err_q[q_head_q]  : 1'b0;

    assign resp_keep = imem_resp_valid && (drop_q == '0) && !redirect_valid;
    assign fault_enq = (state_q == ST_FAULT) && (drop_q == '0) && !redirect_valid;
    assign enq       = resp_keep || fault_enq;
    assign deq       = inst_valid && inst_ready && !redirect_valid;

    always_comb begin
        enq_inst = imem_resp_data;
        enq_pc   = tag_q[tag_head_q];
        enq_err  = imem_resp_err;
        if (fault_enq) begin
            enq_inst = '0;
            enq_pc   = fetch_pc_q;
            enq_err  = 1'b1;
        end
    end

    // In-flight bookkeeping: tags follow memory order regardless of redirects.
    always_comb begin
        tag_d      = tag_q;
        tag_head_d = tag_head_q;
        tag_tail_d = tag_tail_q;
        outst_d    = outst_q + OCW'(req_fire) - OCW'(imem_resp_valid);
        drop_d     = drop_q;
        if (req_fire) begin
            tag_d[tag_tail_q] = fetch_pc_q;
            tag_tail_d = (tag_tail_q == TAW'(MAX_OUTST - 1)) ? '0 : tag_tail_q + TAW'(1);
        end
        if (imem_resp_valid) begin
            tag_head_d = (tag_head_q == TAW'(MAX_OUTST - 1)) ? '0 : tag_head_q + TAW'(1);
            if (drop_q != '0) begin
                drop_d = drop_q - OCW'(1);
            end
        end
        if (redirect_valid) begin
            drop_d = outst_d;
        end
    end

    always_comb begin
        q_inst_d  = q_inst_q;
        q_pc_d    = q_pc_q;
        q_err_d   = q_err_q;
        q_head_d  = q_head_q;
        q_tail_d  = q_tail_q;
        q_count_d = q_count_q;
        if (redirect_valid) begin
            q_head_d  = '0;
            q_tail_d  = '0;
            q_count_d = '0;
        end else begin
            if (enq) begin
                q_inst_d[q_tail_q] = enq_inst;
                q_pc_d[q_tail_q]   = enq_pc;
                q_err_d[q_tail_q]  = enq_err;
                q_tail_d           = q_tail_q + QAW'(1);
            end
            if (deq) begin
                q_head_d = q_head_q + QAW'(1);
            end
            q_count_d = q_count_q + QCW'(enq) - QCW'(deq);
        end
    end

    always_comb begin
        state_d    = state_q;
        fetch_pc_d = fetch_pc_q;
        if (redirect_valid) begin
            fetch_pc_d = redirect_pc;
            state_d    = (redirect_pc[1:0] == 2'b00) ? ST_RUN : ST_FAULT;
        end else begin
            case (state_q)
                ST_RUN: begin
                    if (req_fire) begin
                        fetch_pc_d = fetch_pc_q + XLEN'(4);
                    end
                end
                ST_FAULT: begin
                    if (fault_enq) begin
                        state_d = ST_HALT;
                    end
                end
                ST_HALT:  state_d = ST_HALT;
                default:  state_d = ST_RUN;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_RUN;
            fetch_pc_q <= RESET_PC;
            q_head_q   <= '0;
            q_tail_q   <= '0;
            q_count_q  <= '0;
            tag_head_q <= '0;
            tag_tail_q <= '0;
            outst_q    <= '0;
            drop_q     <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                q_inst_q[i] <= '0;
                q_pc_q[i]   <= '0;
                q_err_q[i]  <= 1'b0;
            end
            for (int i = 0; i < MAX_OUTST; i++) begin
                tag_q[i] <= '0;
            end
        end else begin
            state_q    <= state_d;
            fetch_pc_q <= fetch_pc_d;
            q_inst_q   <= q_inst_d;
            q_pc_q     <= q_pc_d;
            q_err_q    <= q_err_d;
            q_head_q   <= q_head_d;
            q_tail_q   <= q_tail_d;
            q_count_q  <= q_count_d;
            tag_q      <= tag_d;
            tag_head_q <= tag_head_d;
            tag_tail_q <= tag_tail_d;
            outst_q    <= outst_d;
            drop_q     <= drop_d;
        end
    end

endmodule
